// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: run controller for the RV32I_Zicsr core.
// Sequences the CPU reset, counts RUN cycles and watches stores to TOHOST
// for a riscv-tests style pass / fail / timeout verdict.
// Optional feature macro: CPU_TEST_SEQ_PERF_EN (adds o_instret, o_ipc_valid).
module cpu_test_sequencer #(
  parameter int unsigned       RST_CYCLES  = 4,
  parameter int unsigned       MAX_CYCLES  = 100000,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_1000)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  input  logic              i_retire,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [30:0]       o_fail_code,
  output logic [CNT_W-1:0]  o_cycles
`ifdef CPU_TEST_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_instret,
  output logic              o_ipc_valid
`endif
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam bit               TIMEOUT_EN = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      fail_code_q, fail_code_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic hit_c;
  logic last_cycle_c;
  logic start_ok_c;

  // TOHOST stores with odd data terminate the run; even data is ignored
  assign hit_c        = i_mem_we && (i_mem_addr == TOHOST_ADDR) && i_mem_wdata[0];
  assign last_cycle_c = TIMEOUT_EN && (cycles_q == CYC_LAST);
  assign start_ok_c   = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cpu_rst_n_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    cycles_d    = cycles_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_RESET;
          rst_cnt_d   = RST_W'(RST_CYCLES);
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_code_d = 31'd0;
          cycles_d    = '0;
        end
      end

      S_RESET: begin
        busy_d = 1'b1;
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d     = S_RUN;
          cpu_rst_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end

      S_RUN: begin
        cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_W'(1);
        if (hit_c) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          pass_d      = (i_mem_wdata == 32'd1);
          fail_code_d = (i_mem_wdata == 32'd1) ? 31'd0 : i_mem_wdata[31:1];
        end else if (last_cycle_c) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          busy_d      = 1'b1;
          cpu_rst_n_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= 31'd0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      cycles_q    <= cycles_d;
    end
  end

  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_timeout   = timeout_q;
  assign o_fail_code = fail_code_q;
  assign o_cycles    = cycles_q;

`ifdef CPU_TEST_SEQ_PERF_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             ipc_valid_q, ipc_valid_d;

  // Retired-instruction count, RUN cycles only, saturating
  always_comb begin
    instret_d   = instret_q;
    ipc_valid_d = 1'b0;
    if (start_ok_c) begin
      instret_d = '0;
    end else if ((state_q == S_RUN) && i_retire && (instret_q != CNT_MAX)) begin
      instret_d = instret_q + CNT_W'(1);
    end
    ipc_valid_d = (state_d == S_DONE) && (instret_d != '0);
  end

  // Perf counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret_q   <= '0;
      ipc_valid_q <= 1'b0;
    end else begin
      instret_q   <= instret_d;
      ipc_valid_q <= ipc_valid_d;
    end
  end

  assign o_instret   = instret_q;
  assign o_ipc_valid = ipc_valid_q;
`else
  logic unused_perf_c;
  assign unused_perf_c = i_retire ^ start_ok_c;
`endif

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Scoreboard bench for cpu_test_sequencer: directed and random runs are
// modelled per run, expected verdicts queued, and a monitor checks each
// o_done rising edge against the queue.
module tb_cpu_test_sequencer;

  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned MAX_CYCLES = 50;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam logic [31:0] TOHOST     = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              retire;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              pass;
  logic              tmo;
  logic [30:0]       fail_code;
  logic [CNT_W-1:0]  cycles;
`ifdef CPU_TEST_SEQ_PERF_EN
  logic [CNT_W-1:0]  instret;
  logic              ipc_valid;
`endif

  always #5 clk = ~clk;

  cpu_test_sequencer #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W),
    .ADDR_W     (ADDR_W),
    .TOHOST_ADDR(TOHOST)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_mem_we   (we),
    .i_mem_addr (addr),
    .i_mem_wdata(wdata),
    .i_retire   (retire),
    .o_cpu_rst_n(cpu_rst_n),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_timeout  (tmo),
    .o_fail_code(fail_code),
    .o_cycles   (cycles)
`ifdef CPU_TEST_SEQ_PERF_EN
    ,
    .o_instret  (instret),
    .o_ipc_valid(ipc_valid)
`endif
  );

  typedef struct {
    bit          pass;
    bit          tmo;
    bit [30:0]   code;
    int unsigned cycles;
    int unsigned instret;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Per-RUN-cycle stimulus plan for the next run
  bit          s_we   [MAX_CYCLES];
  logic [31:0] s_addr [MAX_CYCLES];
  logic [31:0] s_data [MAX_CYCLES];
  bit          s_rt   [MAX_CYCLES];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first odd-data TOHOST store ends the run, otherwise timeout
  function automatic exp_t model();
    exp_t e;
    int unsigned last;
    e.pass    = 1'b0;
    e.tmo     = 1'b1;
    e.code    = 31'd0;
    e.instret = 0;
    last      = MAX_CYCLES - 1;
    for (int k = 0; k < int'(MAX_CYCLES); k++) begin
      if (s_we[k] && (s_addr[k] == TOHOST) && (s_data[k] % 2 == 1)) begin
        last   = k;
        e.tmo  = 1'b0;
        e.pass = (s_data[k] == 32'd1);
        e.code = e.pass ? 31'd0 : 31'(s_data[k] / 2);
        break;
      end
    end
    e.cycles = last + 1;
    for (int k = 0; k <= int'(last); k++) e.instret += s_rt[k];
    return e;
  endfunction

  function automatic void plan_clear();
    for (int k = 0; k < int'(MAX_CYCLES); k++) begin
      s_we[k]   = 1'b0;
      s_addr[k] = 32'd0;
      s_data[k] = 32'd0;
      s_rt[k]   = 1'b0;
    end
  endfunction

  function automatic void plan_random();
    int unsigned sel;
    int unsigned dsel;
    for (int k = 0; k < int'(MAX_CYCLES); k++) begin
      s_we[k] = ($urandom_range(0, 15) == 0);
      sel     = $urandom_range(0, 3);
      dsel    = $urandom_range(0, 9);
      s_addr[k] = (sel < 2) ? TOHOST : (sel == 2) ? (TOHOST - 32'd4) : $urandom;
      s_data[k] = (dsel < 4) ? ($urandom & 32'hFFFF_FFFE) :
                  (dsel < 7) ? 32'd1 : ($urandom | 32'd1);
      s_rt[k]   = ($urandom_range(0, 1) == 1);
    end
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rst_n"},   cpu_rst_n, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_pass"},    pass, 0);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_code"},    fail_code, 0);
    chk({tag, "_cycles"},  cycles, 0);
`ifdef CPU_TEST_SEQ_PERF_EN
    chk({tag, "_instret"}, instret, 0);
    chk({tag, "_ipc"},     ipc_valid, 0);
`endif
  endtask

  // One run from IDLE/DONE; abort_at >= 0 asserts i_rst in that RUN cycle
  task automatic do_run(input int abort_at);
    exp_t e;
    e = model();
    if (abort_at < 0) sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < int'(RST_CYCLES); r++) begin
      chk("reset_rst_n_low", cpu_rst_n, 0);
      chk("reset_busy", busy, 1);
      if (r == 0) begin
        chk("start_done_clr", done, 0);
        chk("start_pass_clr", pass, 0);
        chk("start_tmo_clr", tmo, 0);
        chk("start_code_clr", fail_code, 0);
        chk("start_cycles_clr", cycles, 0);
      end
      start  = ($urandom_range(0, 1) == 1);
      retire = ($urandom_range(0, 1) == 1);
      we     = ($urandom_range(0, 1) == 1);
      addr   = TOHOST;
      wdata  = 32'd1;
      tick();
    end
    start = 1'b0; retire = 1'b0; we = 1'b0;
    chk("run_rst_n_high", cpu_rst_n, 1);
    chk("run_busy", busy, 1);
    for (int k = 0; k < int'(e.cycles); k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("abort");
        return;
      end
      we     = s_we[k];
      addr   = s_addr[k];
      wdata  = s_data[k];
      retire = s_rt[k];
      start  = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      we     = 1'b1;
      addr   = TOHOST;
      wdata  = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'd7;
      retire = 1'b1;
      tick();
    end
    we = 1'b0; retire = 1'b0;
    chk("hold_done", done, 1);
    chk("hold_pass", pass, e.pass);
    chk("hold_timeout", tmo, e.tmo);
    chk("hold_code", fail_code, e.code);
    chk("hold_cycles", cycles, e.cycles);
    chk("hold_rst_n", cpu_rst_n, 0);
    chk("hold_busy", busy, 0);
`ifdef CPU_TEST_SEQ_PERF_EN
    chk("hold_instret", instret, e.instret);
`endif
    chk("sb_drained", sb.size(), 0);
  endtask

  // Monitor: every rising o_done consumes one expected verdict
  logic prev_done = 1'b0;
  exp_t m_e;
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        m_e = sb.pop_front();
        chk("sb_pass", pass, m_e.pass);
        chk("sb_timeout", tmo, m_e.tmo);
        chk("sb_code", fail_code, m_e.code);
        chk("sb_cycles", cycles, m_e.cycles);
        chk("sb_rst_n", cpu_rst_n, 0);
        chk("sb_busy", busy, 0);
`ifdef CPU_TEST_SEQ_PERF_EN
        chk("sb_instret", instret, m_e.instret);
        chk("sb_ipc_valid", ipc_valid, m_e.instret != 0);
`endif
      end
    end
    prev_done = done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0; wdata = '0; retire = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("por");

    // Pass at RUN cycle 10, 7 retires in RUN
    plan_clear();
    s_we[10] = 1'b1; s_addr[10] = TOHOST; s_data[10] = 32'd1;
    for (int i = 1; i <= 7; i++) s_rt[i] = 1'b1;
    do_run(-1);

    // Wrong address and even data filtered, then fail code 3
    plan_clear();
    s_we[3] = 1'b1; s_addr[3] = 32'h0000_0FFC; s_data[3] = 32'd7;
    s_we[5] = 1'b1; s_addr[5] = TOHOST;        s_data[5] = 32'd2;
    s_we[8] = 1'b1; s_addr[8] = TOHOST;        s_data[8] = 32'd7;
    do_run(-1);

    // Timeout with no stores
    plan_clear();
    do_run(-1);

    // Pass on the final RUN cycle beats timeout
    plan_clear();
    s_we[MAX_CYCLES-1] = 1'b1; s_addr[MAX_CYCLES-1] = TOHOST; s_data[MAX_CYCLES-1] = 32'd1;
    do_run(-1);

    // Mid-run reset at RUN cycle 5, then a fresh run from IDLE
    plan_clear();
    s_we[20] = 1'b1; s_addr[20] = TOHOST; s_data[20] = 32'd1;
    do_run(5);
    plan_random();
    do_run(-1);

    for (int n = 0; n < 25; n++) begin
      plan_random();
      do_run(-1);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
